// File: rtl/enc_grant_scheduler_if.sv
// Request/grant bundle for enc_grant_scheduler.
//   req[7:0]      raw, asynchronous request lines (bit i = requester i)
//   rr_mode       0 = fixed priority, 1 = round-robin (asynchronous)
//   gnt[7:0]      one-hot grant vector, zero when idle
//   gnt_idx[2:0]  binary index of current / last grant
//   gnt_valid     a grant is active
//   timeout       one-cycle pulse on hold-time expiry
//   seg[6:0]      active-low 7-segment digit (bit0 = a)
interface enc_grant_scheduler_if;
    logic [7:0] req;
    logic       rr_mode;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    logic [6:0] seg;

    modport master (
        output req, rr_mode,
        input  gnt, gnt_idx, gnt_valid, timeout, seg
    );

    modport slave (
        input  req, rr_mode,
        output gnt, gnt_idx, gnt_valid, timeout, seg
    );
endinterface

// File: rtl/enc_grant_scheduler.sv
// Grant scheduler: shares one resource among 8 switch-driven requesters.
// Fixed-priority (highest index) or round-robin arbitration, bounded hold
// time with a mandatory one-cycle gap, and a 7-segment display of the grant.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    enc_grant_scheduler_if.slave (req/rr_mode in, grant/display out)
module enc_grant_scheduler #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    enc_grant_scheduler_if.slave  bus
);

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned SYN_W = N_REQ + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SEG_W-1:0] SEG_BLANK = SEG_W'(7'h7F);
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Active-low segment pattern for a grant index.
    function automatic logic [SEG_W-1:0] seg_of(input logic [IDX_W-1:0] idx);
        logic [SEG_W-1:0] pat;
        case (idx)
            3'd0:    pat = 7'h40;
            3'd1:    pat = 7'h79;
            3'd2:    pat = 7'h24;
            3'd3:    pat = 7'h30;
            3'd4:    pat = 7'h19;
            3'd5:    pat = 7'h12;
            3'd6:    pat = 7'h02;
            default: pat = 7'h78;
        endcase
        return pat;
    endfunction

    logic [SYNC_STAGES-1:0][SYN_W-1:0] sync_q, sync_d;
    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [IDX_W-1:0]                  last_q, last_d;
    logic [N_REQ-1:0]                  gnt_q, gnt_d;
    logic [IDX_W-1:0]                  gnt_idx_q, gnt_idx_d;
    logic                              gnt_valid_q, gnt_valid_d;
    logic                              timeout_q, timeout_d;
    logic [SEG_W-1:0]                  seg_q, seg_d;

    logic [N_REQ-1:0] sreq;
    logic             smode;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Request/mode synchroniser shift chain; rr_mode rides in the top bit.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {bus.rr_mode, bus.req};
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sreq  = sync_q[SYNC_STAGES-1][N_REQ-1:0];
    assign smode = sync_q[SYNC_STAGES-1][N_REQ];

    // Winner selection. Round-robin scans last+1 .. last+8 (mod 8), so the
    // previous winner is considered last.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        if (!smode) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (sreq[i]) begin
                    win_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= int'(N_REQ); k++) begin
                cand = last_q + IDX_W'(k);
                if (!found && sreq[cand]) begin
                    win_idx = cand;
                    found   = 1'b1;
                end
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        seg_d       = seg_q;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (|sreq) begin
                    state_d     = ST_GRANT;
                    gnt_d       = N_REQ'(1) << win_idx;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    seg_d       = seg_of(win_idx);
                    cnt_d       = '0;
                    last_d      = win_idx;
                end else begin
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    seg_d       = SEG_BLANK;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A dropped request wins over expiry and suppresses timeout.
                if (!sreq[gnt_idx_q] || (cnt_q == HOLD_LAST)) begin
                    state_d     = ST_GAP;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    seg_d       = SEG_BLANK;
                    timeout_d   = sreq[gnt_idx_q];
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                seg_d       = SEG_BLANK;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= PTR_RESET;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            seg_q       <= SEG_BLANK;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.seg       = seg_q;

endmodule
